// File: rtl/keyvalue_initiator_if.sv
// Command, response and bus signals between a host and the key/value bus initiator.
// Latency: none, this file only bundles wires.
// Backpressure: valid/ready on the command and response sides, and level ACK on the bus.
interface keyvalue_initiator_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  // command port
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_key_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  // response port
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;
  // wishbone-style bus
  logic                  CYC_o;
  logic                  STB_o;
  logic                  WE_o;
  logic [ADDR_WIDTH-1:0] ADR_o;
  logic [DATA_WIDTH-1:0] DAT_o;
  logic [DATA_WIDTH-1:0] KEY_o;
  logic [DATA_WIDTH-1:0] SEL_o;
  logic [DATA_WIDTH-1:0] DAT_i;
  logic                  ACK_i;
  logic                  STALL_i;

  // initiator side
  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_key_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output CYC_o, STB_o, WE_o, ADR_o, DAT_o, KEY_o, SEL_o,
    input  DAT_i, ACK_i, STALL_i
  );

  // host plus responder side
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_key_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  CYC_o, STB_o, WE_o, ADR_o, DAT_o, KEY_o, SEL_o,
    output DAT_i, ACK_i, STALL_i
  );
endinterface

// File: rtl/keyvalue_initiator.sv
// Turns one valid/ready command into one single-beat put/get bus cycle and returns the data or a timeout error.
// Latency: strobe from the cycle after the handshake; response the cycle after ACK is sampled, or after TIMEOUT+1 strobe cycles.
// Backpressure: holds the response until consumed; refuses commands while busy or while a stale ACK is still high.
module keyvalue_initiator #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  keyvalue_initiator_if.master kv
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  cmd_ready;
  logic                  cyc;
  logic                  timeout_hit;
  logic                  unused_stall;

  // The responder's stall only delays its ACK; the strobe is held regardless and the timeout keeps counting.
  assign unused_stall = kv.STALL_i;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO);

  // State and captured command/response registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      key_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      key_q     <= key_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Next-state and handshake logic for one bus cycle per command
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    key_d     = key_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cmd_ready = 1'b0;
    cyc       = 1'b0;
    case (state_q)
      IDLE: begin
        // A level ACK still high belongs to the previous cycle; do not start a new one under it.
        cmd_ready = !kv.ACK_i;
        if (kv.cmd_valid_i && !kv.ACK_i) begin
          we_d    = kv.cmd_we_i;
          adr_d   = kv.cmd_adr_i;
          dat_d   = kv.cmd_dat_i;
          key_d   = kv.cmd_key_i;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        cyc = 1'b1;
        if (kv.ACK_i) begin
          // ACK wins over a timeout in the same cycle
          rsp_dat_d = kv.DAT_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (timeout_hit) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (kv.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs derive from the state register so reset drops them without a clock edge.
  assign kv.cmd_ready_o = cmd_ready && !sys_rst;
  assign kv.CYC_o       = cyc;
  assign kv.STB_o       = cyc;
  assign kv.WE_o        = cyc && we_q;
  assign kv.ADR_o       = cyc ? adr_q : '0;
  assign kv.DAT_o       = cyc ? dat_q : '0;
  assign kv.KEY_o       = cyc ? key_q : '0;
  assign kv.SEL_o       = {DATA_WIDTH{cyc}};
  assign kv.rsp_valid_o = (state_q == RESP);
  assign kv.rsp_dat_o   = rsp_dat_q;
  assign kv.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_keyvalue_initiator.sv
// Bench for keyvalue_initiator: key/value responder, store scoreboard and per-cycle phase model.
// Latency: n/a.
// Backpressure: exercises response stalls and a long-held ACK.
module tb_keyvalue_initiator;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int TMO = 15;
  localparam int P_IDLE = 0, P_ACT = 1, P_RESP = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int checks = 0;
  int errors = 0;

  keyvalue_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) kv ();

  keyvalue_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .kv(kv)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Responder behaviour for the current command: ack after cur_d strobe cycles (0 = never),
  // returning cur_rdat, and keeping ACK up cur_hold extra cycles after the strobe falls.
  int       cur_d = 0;
  int       cur_hold = 0;
  logic [DW-1:0] cur_rdat = '0;
  int       seen;
  int       hold_left;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      kv.ACK_i   <= 1'b0;
      kv.DAT_i   <= '0;
      kv.STALL_i <= 1'b0;
      seen       <= 0;
      hold_left  <= 0;
    end else begin
      kv.STALL_i <= 1'($urandom_range(0, 1));
      if (kv.STB_o) begin
        if (!kv.ACK_i) begin
          if (cur_d != 0 && seen + 1 == cur_d) begin
            kv.ACK_i <= 1'b1;
            kv.DAT_i <= cur_rdat;
          end
          seen <= seen + 1;
        end
        hold_left <= cur_hold;
      end else begin
        seen <= 0;
        if (kv.ACK_i) begin
          if (hold_left == 0) kv.ACK_i <= 1'b0;
          else hold_left <= hold_left - 1;
        end
      end
    end
  end

  // Phase model: a command lasts a computed number of strobe cycles, then waits for consume.
  int       ph = P_IDLE;
  int       m_left = 0;
  bit       m_we, m_err;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat, m_key, m_rdat;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ph <= P_IDLE;
    end else begin
      case (ph)
        P_IDLE: if (kv.cmd_valid_i && !kv.ACK_i) begin
          ph    <= P_ACT;
          m_we  <= kv.cmd_we_i;
          m_adr <= kv.cmd_adr_i;
          m_dat <= kv.cmd_dat_i;
          m_key <= kv.cmd_key_i;
          if (cur_d == 0 || (TMO != 0 && cur_d > TMO)) begin
            m_left <= TMO + 1;
            m_err  <= 1'b1;
            m_rdat <= '0;
          end else begin
            m_left <= cur_d + 1;
            m_err  <= 1'b0;
            m_rdat <= cur_rdat;
          end
        end
        P_ACT: begin
          m_left <= m_left - 1;
          if (m_left == 1) ph <= P_RESP;
        end
        default: if (kv.rsp_ready_i) ph <= P_IDLE;
      endcase
    end
  end

  // Compare process
  always @(negedge sys_clk) begin
    bit act;
    act = (ph == P_ACT);
    chk("cyc", int'(kv.CYC_o), int'(act));
    chk("stb", int'(kv.STB_o), int'(act));
    chk("sel", int'(kv.SEL_o), act ? (1 << DW) - 1 : 0);
    chk("we", int'(kv.WE_o), act ? int'(m_we) : 0);
    chk("adr", int'(kv.ADR_o), act ? int'(m_adr) : 0);
    chk("dat", int'(kv.DAT_o), act ? int'(m_dat) : 0);
    chk("key", int'(kv.KEY_o), act ? int'(m_key) : 0);
    chk("rsp_valid", int'(kv.rsp_valid_o), int'(ph == P_RESP));
    chk("cmd_ready", int'(kv.cmd_ready_o), int'(ph == P_IDLE && !kv.ACK_i && !sys_rst));
    if (ph == P_RESP) begin
      chk("rsp_dat", int'(kv.rsp_dat_o), int'(m_rdat));
      chk("rsp_err", int'(kv.rsp_err_o), int'(m_err));
    end
  end

  // Key/value store scoreboard
  bit            kv_used [16];
  logic [DW-1:0] kv_key  [16];
  logic [DW-1:0] kv_val  [16];

  // Issue one command; caller is at posedge+1. Returns at posedge+1 after the consume.
  task automatic txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] key,
                     input logic [DW-1:0] dat, input int rwait, input int hold, input int dov,
                     output logic [DW-1:0] got_dat, output bit got_err, output int lat,
                     output int stbc, output time hs_t);
    int  slot;
    bit  hit, hs, rdy, done;
    logic [DW-1:0] rd;
    slot = -1;
    hit  = 1'b0;
    rd   = '0;
    if (adr == 0) begin
      for (int i = 0; i < 16; i++) if (slot < 0 && kv_used[i] && kv_key[i] == key) slot = i;
      if (we && slot < 0) for (int i = 0; i < 16; i++) if (slot < 0 && !kv_used[i]) slot = i;
      if (slot >= 0) begin
        hit = 1'b1;
        if (we) begin
          kv_used[slot] = 1'b1;
          kv_key[slot]  = key;
          kv_val[slot]  = dat;
          rd = DW'(slot);
        end else begin
          rd = kv_val[slot];
        end
      end
    end else begin
      hit = 1'b1;
      if (we) begin
        kv_val[adr] = dat;
        rd = DW'(adr);
      end else begin
        rd = kv_val[adr];
      end
    end
    cur_d    = !hit ? 0 : (dov != 0 ? dov : int'($urandom_range(1, 4)));
    cur_rdat = rd;
    cur_hold = hold;
    kv.cmd_we_i    = we;
    kv.cmd_adr_i   = adr;
    kv.cmd_key_i   = key;
    kv.cmd_dat_i   = dat;
    kv.cmd_valid_i = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge sys_clk);
      rdy = kv.cmd_ready_o;
      @(posedge sys_clk);
      if (rdy) hs = 1'b1;
    end
    hs_t = $time;
    if (!hs) chk("cmd_handshake_timeout", 0, 1);
    #1 kv.cmd_valid_i = 1'b0;
    lat  = 1;
    stbc = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge sys_clk);
      if (kv.rsp_valid_o) begin
        done = 1'b1;
      end else begin
        if (kv.STB_o) stbc++;
        @(posedge sys_clk);
        lat++;
      end
    end
    if (!done) chk("rsp_timeout", 0, 1);
    got_dat = kv.rsp_dat_o;
    got_err = kv.rsp_err_o;
    repeat (rwait) @(negedge sys_clk);
    kv.rsp_ready_i = 1'b1;
    @(posedge sys_clk);
    #1 kv.rsp_ready_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] gd;
    bit ge, hs;
    int lat, stbc;
    time t1, t2;
    sys_rst = 1'b1;
    kv.cmd_valid_i = 1'b0;
    kv.cmd_we_i    = 1'b0;
    kv.cmd_adr_i   = '0;
    kv.cmd_key_i   = '0;
    kv.cmd_dat_i   = '0;
    kv.rsp_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      kv_used[i] = 1'b0;
      kv_key[i]  = '0;
      kv_val[i]  = '0;
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_rsp_valid", int'(kv.rsp_valid_o), 0);
    chk("reset_rsp_dat", int'(kv.rsp_dat_o), 0);
    chk("reset_rsp_err", int'(kv.rsp_err_o), 0);
    chk("reset_cyc", int'(kv.CYC_o), 0);
    chk("reset_cmd_ready", int'(kv.cmd_ready_o), 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // put key 5 -> 9 into an empty store: slot 0
    txn(1'b1, 4'd0, 4'd5, 4'd9, 0, 0, 1, gd, ge, lat, stbc, t1);
    chk("put_slot", int'(gd), 0);
    chk("put_err", int'(ge), 0);
    // get key 5, zero-wait responder
    txn(1'b0, 4'd0, 4'd5, 4'd0, 0, 0, 1, gd, ge, lat, stbc, t1);
    chk("get_dat", int'(gd), 9);
    chk("get_latency", lat, 3);
    // miss on key 7
    txn(1'b0, 4'd0, 4'd7, 4'd0, 0, 0, 0, gd, ge, lat, stbc, t1);
    chk("miss_err", int'(ge), 1);
    chk("miss_dat", int'(gd), 0);
    chk("miss_stb_cycles", stbc, TMO + 1);
    // direct slot 3 holds 0xA, read back with 5 cycles of response backpressure
    txn(1'b1, 4'd3, 4'd0, 4'hA, 0, 0, 1, gd, ge, lat, stbc, t1);
    txn(1'b0, 4'd3, 4'd0, 4'd0, 5, 0, 1, gd, ge, lat, stbc, t1);
    chk("direct_get_dat", int'(gd), 10);
    // ACK held 3 cycles past the strobe, then one more command
    txn(1'b1, 4'd0, 4'd2, 4'd4, 0, 2, 1, gd, ge, lat, stbc, t1);
    txn(1'b0, 4'd0, 4'd2, 4'd0, 0, 0, 1, gd, ge, lat, stbc, t1);
    chk("after_hold_dat", int'(gd), 4);
    chk("after_hold_stb_cycles", stbc, 2);
    // ACK arrives exactly as the count reaches TIMEOUT: ACK wins
    txn(1'b0, 4'd0, 4'd5, 4'd0, 0, 0, TMO, gd, ge, lat, stbc, t1);
    chk("edge_ack_err", int'(ge), 0);
    chk("edge_ack_dat", int'(gd), 9);
    chk("edge_ack_stb_cycles", stbc, TMO + 1);
    // back-to-back throughput
    txn(1'b0, 4'd0, 4'd5, 4'd0, 0, 0, 1, gd, ge, lat, stbc, t1);
    txn(1'b0, 4'd0, 4'd5, 4'd0, 0, 0, 1, gd, ge, lat, stbc, t2);
    chk("b2b_spacing_ns", int'(t2 - t1), 40);

    // reset mid-ACTIVE
    cur_d = 0;
    cur_hold = 0;
    kv.cmd_we_i = 1'b0;
    kv.cmd_adr_i = '0;
    kv.cmd_key_i = 4'd7;
    kv.cmd_valid_i = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge sys_clk);
      hs = kv.cmd_ready_o;
      @(posedge sys_clk);
    end
    if (!hs) chk("rst_test_handshake_timeout", 0, 1);
    #1 kv.cmd_valid_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    chk("async_rst_cyc", int'(kv.CYC_o), 0);
    chk("async_rst_stb", int'(kv.STB_o), 0);
    chk("async_rst_rsp_valid", int'(kv.rsp_valid_o), 0);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    txn(1'b0, 4'd0, 4'd5, 4'd0, 0, 0, 1, gd, ge, lat, stbc, t1);
    chk("post_rst_dat", int'(gd), 9);
    chk("post_rst_stb_cycles", stbc, 2);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit we;
      logic [AW-1:0] adr;
      int dov;
      we  = 1'($urandom_range(0, 1));
      adr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1, 15)) : '0;
      dov = ($urandom_range(0, 7) == 0) ? TMO : 0;
      txn(we, adr, DW'($urandom_range(0, 7)), DW'($urandom_range(0, 15)),
          $urandom_range(0, 3), $urandom_range(0, 3), dov, gd, ge, lat, stbc, t1);
      repeat ($urandom_range(0, 2)) @(posedge sys_clk);
      #1;
    end

    repeat (3) @(posedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
